// File: rtl/qsim_pkg.sv
// Shared definitions for the qubit measurement sampler.
//   RND_W_DEFAULT : default width of the random word and probability threshold
//   state_e       : batch sequencer states (idle, running shots, draining last outcome)
package qsim_pkg;

  localparam int unsigned RND_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/qubit_measure_sampler.sv
// Qubit measurement sampler: turns a stream of uniform random words into a batch of
// single-qubit measurement outcomes with P(|0>) = p0 / 2^RND_W.
// Ports:
//   clk, reset             : clock, synchronous active-low reset
//   start, p0, shots       : batch request; p0 and shots are captured on an accepted start
//   rnd_in/rnd_valid/rnd_ready : random word stream (one word consumed per shot)
//   out_bit/out_valid/out_ready: outcome stream (0 = |0>, 1 = |1>)
//   busy, done             : batch in progress; one-cycle completion pulse
//   count_zero, count_one  : outcome tallies for the current or last batch
module qubit_measure_sampler
  import qsim_pkg::*;
#(
  parameter int unsigned SHOT_W = 16,
  parameter int unsigned RND_W  = RND_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [RND_W-1:0]  p0,
  input  logic [SHOT_W-1:0] shots,
  input  logic [RND_W-1:0]  rnd_in,
  input  logic              rnd_valid,
  output logic              rnd_ready,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [SHOT_W-1:0] count_zero,
  output logic [SHOT_W-1:0] count_one
);

  state_e            state_q;
  logic [RND_W-1:0]  p0_q;
  logic [SHOT_W-1:0] remaining_q;
  logic              out_bit_q;
  logic              out_valid_q;
  logic              done_q;
  logic [SHOT_W-1:0] count_zero_q;
  logic [SHOT_W-1:0] count_one_q;

  logic consume;
  logic sample;

  // A new word may be taken whenever the output slot is empty or is emptied this cycle.
  assign rnd_ready = (state_q == StRun) && (!out_valid_q || out_ready);
  assign consume   = rnd_valid && rnd_ready;

  // Words below the threshold fall into the |0> region of the unit interval.
  assign sample = (rnd_in < p0_q) ? 1'b0 : 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      p0_q         <= '0;
      remaining_q  <= '0;
      out_bit_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      count_zero_q <= '0;
      count_one_q  <= '0;
    end else begin
      done_q <= 1'b0;
      // A consume below overrides this clear, so back-to-back outcomes never gap.
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            count_zero_q <= '0;
            count_one_q  <= '0;
            if (shots != '0) begin
              p0_q        <= p0;
              remaining_q <= shots;
              state_q     <= StRun;
            end else begin
              done_q <= 1'b1;
            end
          end
        end

        StRun: begin
          if (consume) begin
            remaining_q <= remaining_q - SHOT_W'(1);
            out_bit_q   <= sample;
            out_valid_q <= 1'b1;
            if (sample) begin
              count_one_q <= count_one_q + SHOT_W'(1);
            end else begin
              count_zero_q <= count_zero_q + SHOT_W'(1);
            end
            if (remaining_q == SHOT_W'(1)) begin
              state_q <= StDrain;
            end
          end
        end

        StDrain: begin
          // Completion is signalled only once the final outcome has been accepted.
          if (out_valid_q && out_ready) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_bit    = out_bit_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign busy       = (state_q != StIdle);
  assign count_zero = count_zero_q;
  assign count_one  = count_one_q;

endmodule
